dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (CPU master) and the UART program/data loader (DMA master).
- The CPU has default priority. A starvation counter forces short DMA bursts, during which the pipeline is frozen through cpu_stall.
- The block sits between the EX/MEM pipeline register outputs and DataMem, and replaces the direct CPU-to-DataMem connection.

Parameters:
- ADDR_W, 32, address width for both masters and memory.
- DATA_W, 32, data width.
- MAX_WAIT, 8, consecutive denied DMA-request cycles before a forced grant; legal range 1..255.
- BURST_MAX, 4, maximum consecutive DMA grants per forced burst, counting the forcing grant; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  MEM-stage read request.
- cpu_wr  in  1  MEM-stage write request.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; mem_rdata passed through combinationally.
- cpu_stall  out  1  freeze PC and all pipeline registers this cycle; the CPU access replays next cycle.
- dma_req  in  1  DMA request; held with its addr/data until dma_gnt.
- dma_wr  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  combinational; high in the cycle the DMA access hits memory.
- dma_rdata  out  DATA_W  registered read data.
- dma_rvalid  out  1  one-cycle pulse, the cycle after a granted DMA read.
- mem_rd  out  1  to DataMem rd.
- mem_wr  out  1  to DataMem wr.
- mem_addr  out  ADDR_W  to DataMem addr.
- mem_wdata  out  DATA_W  to DataMem wdata.
- mem_rdata  in  DATA_W  DataMem rdata; combinational read.
- dma_owner  out  1  registered; 1 while in ARB_BURST (debug/LED).

Behaviour:
- Definitions: cpu_req = cpu_rd | cpu_wr. DataMem reads are combinational; writes take effect on the clock edge.
- Exactly one owner per cycle. The owner's rd/wr/addr/wdata are muxed onto mem_*. The non-owner's request has no memory effect.
- Muxing is combinational from the state register, counters and current inputs. Zero added latency for the CPU when it is not stalled.
- States: ARB_CPU (reset state) and ARB_BURST.
- Registers: wait_cnt (0..MAX_WAIT) and burst_cnt (0..BURST_MAX).
- ARB_CPU:
  - dma_req & (!cpu_req | wait_cnt==MAX_WAIT): DMA granted, dma_gnt=1, cpu_stall=cpu_req.
  - The grant is forced when wait_cnt==MAX_WAIT and cpu_req=1. A forced grant moves to ARB_BURST with burst_cnt=1.
  - A grant to an idle-CPU cycle (opportunistic) stays in ARB_CPU.
  - Otherwise the CPU owns the bus, dma_gnt=0, cpu_stall=0.
- ARB_BURST:
  - dma_req & burst_cnt<BURST_MAX: DMA granted, cpu_stall=cpu_req, burst_cnt++.
  - Otherwise (dma_req low, or burst_cnt==BURST_MAX): return to ARB_CPU, burst_cnt=0.
  - The exit cycle is arbitrated with ARB_CPU rules using wait_cnt=0, so the CPU wins if it requests.
- wait_cnt:
  - Cleared when dma_req=0, or when dma_gnt=1.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Forced cleared on entry to ARB_BURST.
- DMA read: when dma_gnt & !dma_wr, mem_rdata is captured into dma_rdata at the edge, and dma_rvalid=1 the following cycle only. dma_rdata holds its value until the next granted read.
- DMA write: commits at the edge ending the grant cycle.
- cpu_rdata always equals mem_rdata. It is only meaningful when the CPU owns the bus and cpu_stall=0.
- No request at all: mem_rd=mem_wr=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- cpu_rd & cpu_wr together: illegal, and the design does not protect against it. Both strobes are forwarded unchanged to mem_rd and mem_wr.
- Reset values (reset low, asynchronous):
  - State ARB_CPU, wait_cnt=0, burst_cnt=0.
  - dma_rdata=0, dma_rvalid=0, dma_owner=0.
  - Combinational outputs (dma_gnt, cpu_stall, mem_rd, mem_wr) are forced to 0 while reset is low.
- Reset mid-burst: the burst is abandoned and no pending dma_rvalid is emitted. The DMA master must re-request after reset.

Decomposition:
- Shared package: ARB_CPU/ARB_BURST state encoding (1 bit) and defaults for MAX_WAIT/BURST_MAX. The same package is shared with the loader block.
- No sub-module; the counters are simple enough to stay inline.

Test Plan:
- CPU-only traffic: CPU writes 0xDEADBEEF to 0x10, then reads 0x10 -> cpu_rdata=0xDEADBEEF, cpu_stall never asserted, dma_gnt=0.
- DMA with idle CPU: DMA read at 0x20 holding 0x12345678 -> dma_gnt in the same cycle, dma_rvalid next cycle with dma_rdata=0x12345678, state stays ARB_CPU.
- Starvation, MAX_WAIT=8, BURST_MAX=4: cpu_req held high and dma_req high from cycle 0 -> dma_gnt first in cycle 8, then cycles 8-11 granted with cpu_stall=1. Cycle 12 goes to the CPU with cpu_stall=0, wait_cnt restarts, next forced grant in cycle 20.
- Early burst exit: dma_req drops after 2 burst grants -> ARB_BURST to ARB_CPU, the CPU owns the bus in that cycle, burst_cnt=0.
- Simultaneous CPU write and DMA write to 0x40: during the forced grant, memory holds the DMA value. The stalled CPU write replays next cycle and the final value equals the CPU value.
- Reset asserted during burst cycle 2 -> all outputs 0 immediately (asynchronously); after release the state is ARB_CPU, no dma_rvalid, and a CPU access proceeds without stall.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared arbitration definitions for the data-memory arbiter and the UART loader.
// Holds the one-bit state encoding and the default starvation/burst limits.
package dmem_arbiter_pkg;

   typedef enum logic {
      ARB_CPU   = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   localparam int DEFAULT_MAX_WAIT  = 8;
   localparam int DEFAULT_BURST_MAX = 4;

   // Both limits are legal up to 255, so 8-bit counters cover every setting.
   localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MEM stage (CPU) and the UART loader (DMA).
// CPU has priority; a starvation counter forces short DMA bursts that stall the pipeline.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_WAIT  = DEFAULT_MAX_WAIT,
   parameter int BURST_MAX = DEFAULT_BURST_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_wr,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              dma_owner
);

   localparam logic [CNT_W-1:0] MAX_WAIT_C  = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_nxt;
   logic             cpu_req;
   logic             grant;

   assign cpu_req = cpu_rd | cpu_wr;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      burst_nxt = '0;
      grant     = 1'b0;
      wait_nxt  = wait_cnt;
      case (state)
         ARB_CPU: begin
            grant = dma_req & (~cpu_req | (wait_cnt == MAX_WAIT_C));
            if (grant & cpu_req) begin
               state_nxt = ARB_BURST;
               burst_nxt = CNT_W'(1);
            end
         end
         ARB_BURST: begin
            if (dma_req & (burst_cnt < BURST_MAX_C)) begin
               grant     = 1'b1;
               burst_nxt = burst_cnt + CNT_W'(1);
            end else begin
               // Exit cycle behaves like ARB_CPU with an empty wait count: CPU wins.
               state_nxt = ARB_CPU;
               grant     = dma_req & ~cpu_req;
            end
         end
         default: state_nxt = ARB_CPU;
      endcase

      if (!dma_req || grant) begin
         wait_nxt = '0;
      end else if (wait_cnt != MAX_WAIT_C) begin
         wait_nxt = wait_cnt + CNT_W'(1);
      end
   end

   // NOTE: strobes are gated with reset so memory and the pipeline see nothing while reset is low.
   always_comb begin
      dma_gnt   = reset & grant;
      cpu_stall = reset & grant & cpu_req;
      mem_rd    = reset & (grant ? ~dma_wr : cpu_rd);
      mem_wr    = reset & (grant ?  dma_wr : cpu_wr);
      mem_addr  = grant ? dma_addr  : cpu_addr;
      mem_wdata = grant ? dma_wdata : cpu_wdata;
   end

   assign cpu_rdata = mem_rdata;
   assign dma_owner = (state == ARB_BURST);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ARB_CPU;
         wait_cnt   <= '0;
         burst_cnt  <= '0;
         dma_rdata  <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_nxt;
         burst_cnt  <= burst_nxt;
         dma_rvalid <= grant & ~dma_wr;
         if (grant & ~dma_wr) begin
            dma_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model and a shadow copy of DataMem.
module tb_dmem_arbiter;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_WAIT  = 8;
   localparam int BURST_MAX = 4;

   logic              clk;
   logic              reset;
   logic              cpu_rd, cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              dma_req, dma_wr;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_rvalid;
   logic              mem_rd, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              dma_owner;

   dmem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dma_owner(dma_owner)
   );

   // DataMem stand-in: combinational read, write on the rising edge.
   logic [31:0] dmem [256] = '{default: 32'h0};
   assign mem_rdata = dmem[mem_addr[7:0]];
   always @(posedge clk) if (mem_wr) dmem[mem_addr[7:0]] <= mem_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] shadow [256];
   int          starve;      // consecutive denied DMA-request cycles
   int          burst_len;   // grants so far in the current forced burst, 0 = none
   bit          exp_rvalid;
   logic [31:0] exp_rdata;
   bit          last_gnt, last_stall;
   int          cyc;
   int          n_vec, n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      starve     = 0;
      burst_len  = 0;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
      last_gnt   = 1'b0;
      last_stall = 1'b0;
   endtask

   // Called right after the inputs change at the falling edge; checks, then advances the model.
   task automatic cycle();
      bit creq, g;
      int nb;
      #1;
      creq = cpu_rd | cpu_wr;
      if (burst_len > 0) begin
         if (dma_req && burst_len < BURST_MAX) begin
            g  = 1'b1;
            nb = burst_len + 1;
         end else begin
            g  = dma_req && !creq;
            nb = 0;
         end
      end else begin
         g  = dma_req && (!creq || starve == MAX_WAIT);
         nb = (g && creq) ? 1 : 0;
      end

      check("dma_gnt",    32'(dma_gnt),    32'(g));
      check("cpu_stall",  32'(cpu_stall),  32'(g && creq));
      check("mem_rd",     32'(mem_rd),     32'(g ? !dma_wr : cpu_rd));
      check("mem_wr",     32'(mem_wr),     32'(g ? dma_wr : cpu_wr));
      check("mem_addr",   mem_addr,        g ? dma_addr : cpu_addr);
      if (g ? dma_wr : cpu_wr) check("mem_wdata", mem_wdata, g ? dma_wdata : cpu_wdata);
      check("dma_owner",  32'(dma_owner),  32'(burst_len > 0));
      check("dma_rvalid", 32'(dma_rvalid), 32'(exp_rvalid));
      check("dma_rdata",  dma_rdata,       exp_rdata);
      if (cpu_rd && !g) check("cpu_rdata", cpu_rdata, shadow[cpu_addr[7:0]]);

      exp_rvalid = g && !dma_wr;
      if (exp_rvalid) exp_rdata = shadow[dma_addr[7:0]];
      if (g && dma_wr)        shadow[dma_addr[7:0]] = dma_wdata;
      else if (!g && cpu_wr)  shadow[cpu_addr[7:0]] = cpu_wdata;
      if (!dma_req || g)          starve = 0;
      else if (starve < MAX_WAIT) starve = starve + 1;
      burst_len  = nb;
      last_gnt   = g;
      last_stall = g && creq;
      cyc++;
   endtask

   task automatic tick(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
      @(negedge clk);
      cpu_rd = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_wr = dw; dma_addr = da; dma_wdata = dd;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
   endtask

   localparam logic [31:0] VAL_A = 32'hC0C0_0001;
   localparam logic [31:0] VAL_B = 32'hD0D0_0002;

   initial begin
      int r;
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      model_reset();

      // Reset with live requests: strobes must stay low.
      reset = 1'b0;
      cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
      dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h20; dma_wdata = '0;
      #12;
      check("rst_gnt",    32'(dma_gnt),    32'h0);
      check("rst_stall",  32'(cpu_stall),  32'h0);
      check("rst_mem_rd", 32'(mem_rd),     32'h0);
      check("rst_rvalid", 32'(dma_rvalid), 32'h0);
      check("rst_owner",  32'(dma_owner),  32'h0);
      check("rst_rdata",  dma_rdata,       32'h0);
      cpu_rd = 1'b0; dma_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // CPU-only traffic
      tick(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
      tick(1, 0, 32'h10, 32'h0,         0, 0, 32'h0, 32'h0);
      check("cpu_only_rdata", cpu_rdata, 32'hDEAD_BEEF);
      check("cpu_only_stall", 32'(cpu_stall), 32'h0);

      // DMA read with idle CPU
      tick(0, 1, 32'h20, 32'h1234_5678, 0, 0, 32'h0, 32'h0);
      tick(0, 0, 32'h0,  32'h0,         1, 0, 32'h20, 32'h0);
      check("idle_dma_gnt", 32'(dma_gnt), 32'h1);
      idle(1);
      check("idle_dma_rvalid", 32'(dma_rvalid), 32'h1);
      check("idle_dma_rdata",  dma_rdata, 32'h1234_5678);
      check("idle_dma_owner",  32'(dma_owner), 32'h0);

      // Starvation: grants in cycles 8..11 and again from 20
      idle(2);
      for (int c = 0; c <= 20; c++) begin
         tick(1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
         check("starve_gnt",   32'(dma_gnt),   32'((c >= 8 && c <= 11) || c == 20));
         check("starve_stall", 32'(cpu_stall), 32'((c >= 8 && c <= 11) || c == 20));
      end
      idle(2);

      // Early burst exit after two grants
      for (int c = 0; c <= 9; c++) tick(1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
      tick(1, 0, 32'h0, 32'h0, 0, 0, 32'h4, 32'h0);
      check("exit_gnt",   32'(dma_gnt),   32'h0);
      check("exit_stall", 32'(cpu_stall), 32'h0);
      check("exit_owner", 32'(dma_owner), 32'h1);
      check("exit_addr",  mem_addr,       32'h0);
      tick(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      check("exit_owner_after", 32'(dma_owner), 32'h0);
      idle(1);

      // Colliding writes to 0x40: DMA lands first, replayed CPU write wins
      for (int c = 0; c <= 7; c++) tick(0, 1, 32'h44, 32'(c), 1, 1, 32'h40, VAL_B);
      tick(0, 1, 32'h40, VAL_A, 1, 1, 32'h40, VAL_B);
      check("collide_gnt",   32'(dma_gnt),   32'h1);
      check("collide_stall", 32'(cpu_stall), 32'h1);
      tick(0, 1, 32'h40, VAL_A, 0, 0, 32'h0, 32'h0);
      check("collide_mem_dma", dmem[8'h40], VAL_B);
      check("collide_replay_stall", 32'(cpu_stall), 32'h0);
      idle(1);
      check("collide_mem_cpu", dmem[8'h40], VAL_A);

      // Reset during burst cycle 2
      idle(1);
      for (int c = 0; c <= 8; c++) tick(1, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
      tick(1, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_gnt",    32'(dma_gnt),    32'h0);
      check("midrst_stall",  32'(cpu_stall),  32'h0);
      check("midrst_mem_rd", 32'(mem_rd),     32'h0);
      check("midrst_mem_wr", 32'(mem_wr),     32'h0);
      check("midrst_owner",  32'(dma_owner),  32'h0);
      check("midrst_rvalid", 32'(dma_rvalid), 32'h0);
      check("midrst_rdata",  dma_rdata,       32'h0);
      model_reset();
      cpu_rd = 1'b0; dma_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
      check("postrst_stall", 32'(cpu_stall), 32'h0);
      check("postrst_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // Randomized traffic; stalled CPU accesses and ungranted DMA requests are held.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (!last_stall) begin
            r = $urandom_range(0, 4);
            cpu_rd    = (r == 1 || r == 2);
            cpu_wr    = (r >= 3);
            cpu_addr  = 32'($urandom_range(0, 15)) << 2;
            cpu_wdata = $urandom;
         end
         if (!dma_req || last_gnt) begin
            dma_req   = ($urandom_range(0, 3) != 0);
            dma_wr    = $urandom_range(0, 1) != 0;
            dma_addr  = 32'($urandom_range(0, 15)) << 2;
            dma_wdata = $urandom;
         end
         cycle();
      end
      idle(3);

      for (int i = 0; i < 256; i++) check("final_mem", dmem[i], shadow[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
